mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle control FSM for the MIPS subset datapath; the driving end of the ALU interface.
//  Decodes opcode/funct, sequences FETCH/DECODE/EXEC/MEM/WB and issues alu_op to the ALU.
//  Consumes the ALU zero flag (JSignal) to resolve beq, and handshakes with instr and data memory.
//  Sits between the IR/PC/GRF/DM datapath and the ALU in the multi-cycle CPU top.
// PARAMETERS
//  ALUOP_W  4   alu_op width; encoding: 0000 add, 0001 sub, 0010 or, 0011 and, 0100 lui
//  CNT_W    32  width of retired-instruction counter
// PORTS
//  clk         in   1        single clock, all state updates on posedge
//  reset       in   1        synchronous, active-low (0 = reset)
//  opcode      in   6        IR[31:26]
//  funct       in   6        IR[5:0]
//  zero        in   1        ALU JSignal (result == 0)
//  imem_ready  in   1        instr word valid this cycle
//  dmem_ready  in   1        data access completes this cycle
//  ir_we       out  1        latch instr into IR
//  pc_we       out  1        PC write enable
//  pc_src      out  2        00 PC+4, 01 branch target, 10 jump imm26, 11 rs (jr)
//  alu_op      out  ALUOP_W  ALU operation
//  alu_src_b   out  1        0 rt data, 1 extended imm16
//  ext_op      out  1        0 zero-extend, 1 sign-extend
//  reg_we      out  1        GRF write enable
//  reg_dst     out  2        00 rt, 01 rd, 10 $31
//  wb_sel      out  2        00 ALU result, 01 mem data, 10 PC reg (already PC+4)
//  dmem_re     out  1        data read request
//  dmem_we     out  1        data write request
//  illegal     out  1        one-cycle pulse on undecodable instr
//  state       out  3        current state (debug)
//  instr_cnt   out  CNT_W    retired count (0 when macro absent)
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4; 5-7 unreachable -> FETCH next cycle.
//  - Outputs combinational from state + decode + ready; default 0 in every state.
//  - Reset (reset==0 at posedge): state<=FETCH, counter<=0; while reset low every output is 0.
//  - Reset mid-instruction aborts it; no reg/mem/pc write in the reset cycle.
//  - FETCH: wait for imem_ready; then ir_we=1, pc_we=1, pc_src=00, -> DECODE. No ready -> stay.
//  - DECODE: nop (opcode 0, funct 0) -> FETCH; unknown opcode/funct -> illegal=1, -> FETCH (no retire);
//    else -> EXEC.
//  - EXEC addu/subu: alu_op add/sub, src_b 0, -> WB. ori: or, src_b 1, ext 0, -> WB.
//    lui: lui, src_b 1, -> WB. lw/sw: add, src_b 1, ext 1, -> MEM.
//    beq: sub, src_b 0, pc_src 01, pc_we=zero, -> FETCH. j: pc_we, src 10, -> FETCH.
//    jal: pc_we src 10 + reg_we, reg_dst 10, wb_sel 10 same cycle, -> FETCH. jr: pc_we src 11 -> FETCH.
//  - MEM: lw holds dmem_re, sw holds dmem_we until dmem_ready; alu_op/src/ext held as in EXEC.
//    lw+ready -> WB; sw+ready -> FETCH.
//  - WB: reg_we=1 one cycle; reg_dst 01 (R-type) else 00; wb_sel 01 (lw) else 00; -> FETCH.
//  - Latency at zero wait: nop 2, beq/j/jal/jr 3, R/ori/lui/sw 4, lw 5 cycles.
//  - Retire = transition into FETCH from EXEC/MEM/WB, or from DECODE on nop.
// CONFIGURATION
//  MC_CTRL_PERF_EN defined: instr_cnt += 1 on each retire, wraps 2^CNT_W-1 -> 0, reset to 0.
//  Undefined: no counter register; instr_cnt tied to 0. Port list identical both ways.
// STRUCTURE
//  Shared header mc_defs.vh: opcode/funct constants, ALUOp codes, state codes, pc_src/reg_dst/wb_sel codes.
//  Sub-module mc_decode: combinational opcode/funct -> one-hot instr class + illegal.
// TESTING
//  - reset=0 for 2 cycles, imem_ready=1 -> all outputs 0, state=0; release -> ir_we=pc_we=1 next cycle.
//  - addu ($rd=rs+rt), imem_ready stuck 0 for 3 cycles -> FETCH held, then D,E(alu_op 0000),W(reg_we, reg_dst 01) in 3 cycles.
//  - beq zero=1 -> EXEC pc_we=1 pc_src=01 alu_op=0001; zero=0 -> pc_we=0; both back to FETCH after 3 cycles.
//  - lw with dmem_ready low 2 cycles -> dmem_re high 3 MEM cycles, then WB wb_sel=01 reg_dst=00; sw never reg_we.
//  - opcode 6'h3F -> illegal pulse in DECODE, FETCH next, instr_cnt unchanged; jal -> reg_dst 10, wb_sel 10.
//  - MC_CTRL_PERF_EN, 5 retires then reset=0 mid-EXEC -> instr_cnt 5 then 0, no reg_we; force count 2^32-1 -> wraps to 0.

Source files
------------

// File: rtl/mc_ctrl_fsm_pkg.sv
// rtl/mc_ctrl_fsm_pkg.sv - shared encodings for the multi-cycle control FSM
package mc_ctrl_fsm_pkg;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_NOP  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0100;

  localparam logic [1:0] PC_SRC_PC4 = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_J   = 2'b10;
  localparam logic [1:0] PC_SRC_JR  = 2'b11;

  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC  = 2'b10;

  typedef struct packed {
    logic nop;
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
  } instr_class_t;

  function automatic logic is_rtype(instr_class_t c);
    return c.addu | c.subu;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_decode.sv
// rtl/mc_ctrl_fsm_decode.sv - opcode/funct to one-hot instruction class plus illegal flag
module mc_ctrl_fsm_decode
  import mc_ctrl_fsm_pkg::*;
(
  input  logic [5:0]   opcode,
  input  logic [5:0]   funct,
  output instr_class_t cls,
  output logic         illegal
);

  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_NOP:  cls.nop  = 1'b1;
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: illegal  = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle MIPS-subset control FSM driving the ALU and memories
// Optional retired-instruction counter enabled by MC_CTRL_PERF_EN.
module mc_ctrl_fsm
  import mc_ctrl_fsm_pkg::*;
#(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               alu_src_b,
  output logic               ext_op,
  output logic               reg_we,
  output logic [1:0]         reg_dst,
  output logic [1:0]         wb_sel,
  output logic               dmem_re,
  output logic               dmem_we,
  output logic               illegal,
  output logic [2:0]         state,
  output logic [CNT_W-1:0]   instr_cnt
);

  instr_class_t cls;
  logic         dec_illegal;

  mc_ctrl_fsm_decode u_decode (
    .opcode  (opcode),
    .funct   (funct),
    .cls     (cls),
    .illegal (dec_illegal)
  );

  logic [2:0] state_q, state_d;
  logic       ir_we_c, pc_we_c, alu_src_b_c, ext_op_c, reg_we_c;
  logic       dmem_re_c, dmem_we_c, illegal_c;
  logic [1:0] pc_src_c, reg_dst_c, wb_sel_c;
  logic [3:0] alu_op_c;

  always_comb begin
    state_d     = state_q;
    ir_we_c     = 1'b0;
    pc_we_c     = 1'b0;
    pc_src_c    = PC_SRC_PC4;
    alu_op_c    = ALU_ADD;
    alu_src_b_c = 1'b0;
    ext_op_c    = 1'b0;
    reg_we_c    = 1'b0;
    reg_dst_c   = REG_DST_RT;
    wb_sel_c    = WB_SEL_ALU;
    dmem_re_c   = 1'b0;
    dmem_we_c   = 1'b0;
    illegal_c   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (imem_ready) begin
          ir_we_c = 1'b1;
          pc_we_c = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (cls.nop || dec_illegal) begin
          illegal_c = dec_illegal;
          state_d   = ST_FETCH;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        if (cls.addu || cls.subu) begin
          alu_op_c = cls.subu ? ALU_SUB : ALU_ADD;
          state_d  = ST_WB;
        end else if (cls.ori || cls.lui) begin
          alu_op_c    = cls.ori ? ALU_OR : ALU_LUI;
          alu_src_b_c = 1'b1;
          state_d     = ST_WB;
        end else if (cls.lw || cls.sw) begin
          alu_src_b_c = 1'b1;
          ext_op_c    = 1'b1;
          state_d     = ST_MEM;
        end else if (cls.beq) begin
          alu_op_c = ALU_SUB;
          pc_src_c = PC_SRC_BR;
          pc_we_c  = zero;
        end else if (cls.j || cls.jal) begin
          pc_we_c  = 1'b1;
          pc_src_c = PC_SRC_J;
          if (cls.jal) begin
            // Link written in the same cycle: the PC register already holds PC+4.
            reg_we_c  = 1'b1;
            reg_dst_c = REG_DST_RA;
            wb_sel_c  = WB_SEL_PC;
          end
        end else if (cls.jr) begin
          pc_we_c  = 1'b1;
          pc_src_c = PC_SRC_JR;
        end
      end
      ST_MEM: begin
        alu_src_b_c = 1'b1;
        ext_op_c    = 1'b1;
        dmem_re_c   = cls.lw;
        dmem_we_c   = cls.sw;
        if (!(cls.lw || cls.sw)) begin
          state_d = ST_FETCH;
        end else if (dmem_ready) begin
          state_d = cls.lw ? ST_WB : ST_FETCH;
        end
      end
      ST_WB: begin
        reg_we_c  = 1'b1;
        reg_dst_c = is_rtype(cls) ? REG_DST_RD : REG_DST_RT;
        wb_sel_c  = cls.lw ? WB_SEL_MEM : WB_SEL_ALU;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Every output is forced low while reset is asserted so an aborted instruction writes nothing.
  assign ir_we     = reset & ir_we_c;
  assign pc_we     = reset & pc_we_c;
  assign pc_src    = reset ? pc_src_c : 2'b00;
  assign alu_op    = reset ? ALUOP_W'(alu_op_c) : '0;
  assign alu_src_b = reset & alu_src_b_c;
  assign ext_op    = reset & ext_op_c;
  assign reg_we    = reset & reg_we_c;
  assign reg_dst   = reset ? reg_dst_c : 2'b00;
  assign wb_sel    = reset ? wb_sel_c : 2'b00;
  assign dmem_re   = reset & dmem_re_c;
  assign dmem_we   = reset & dmem_we_c;
  assign illegal   = reset & illegal_c;
  assign state     = reset ? state_q : 3'd0;

`ifdef MC_CTRL_PERF_EN
  logic             retire;
  logic [CNT_W-1:0] cnt_q;

  assign retire = (state_d == ST_FETCH) &&
                  ((state_q == ST_EXEC) || (state_q == ST_MEM) || (state_q == ST_WB) ||
                   ((state_q == ST_DECODE) && cls.nop));

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (retire) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign instr_cnt = reset ? cnt_q : '0;
`else
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - self-checking bench for mc_ctrl_fsm against a phase-trace reference model
module tb_mc_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        zero, imem_ready, dmem_ready;
  logic        ir_we, pc_we, alu_src_b, ext_op, reg_we, dmem_re, dmem_we, illegal;
  logic [1:0]  pc_src, reg_dst, wb_sel;
  logic [3:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.ALUOP_W(4), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_op(alu_op), .alu_src_b(alu_src_b), .ext_op(ext_op),
    .reg_we(reg_we), .reg_dst(reg_dst), .wb_sel(wb_sel), .dmem_re(dmem_re),
    .dmem_we(dmem_we), .illegal(illegal), .state(state), .instr_cnt(instr_cnt)
  );

`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int K_NOP = 0, K_ADDU = 1, K_SUBU = 2, K_ORI = 3, K_LUI = 4, K_LW = 5, K_SW = 6;
  localparam int K_BEQ = 7, K_J = 8, K_JAL = 9, K_JR = 10, K_ILL_OP = 11, K_ILL_FN = 12;

  typedef struct packed {
    logic [2:0] st;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       src_b;
    logic       ext;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wb_sel;
    logic       re;
    logic       we;
    logic       ill;
  } outv_t;

  typedef struct {
    outv_t o;
    logic  imem_rdy;
    logic  dmem_rdy;
    logic  zero;
  } rec_t;

  rec_t        trace[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] cnt_model = 0;

  function automatic logic [5:0] op_of(int kind);
    case (kind)
      K_ORI:    return 6'h0D;
      K_LUI:    return 6'h0F;
      K_LW:     return 6'h23;
      K_SW:     return 6'h2B;
      K_BEQ:    return 6'h04;
      K_J:      return 6'h02;
      K_JAL:    return 6'h03;
      K_ILL_OP: return 6'h3F;
      default:  return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] fn_of(int kind);
    case (kind)
      K_NOP:    return 6'h00;
      K_ADDU:   return 6'h21;
      K_SUBU:   return 6'h23;
      K_JR:     return 6'h08;
      K_ILL_FN: return 6'h3F;
      default:  return 6'($urandom);
    endcase
  endfunction

  function automatic rec_t mk(logic [2:0] st, logic z);
    rec_t r;
    r.o        = '0;
    r.o.st     = st;
    r.imem_rdy = 1'($urandom);
    r.dmem_rdy = 1'($urandom);
    r.zero     = z;
    return r;
  endfunction

  // Expected per-cycle trace: fetch waits, fetch, decode, then the phases each instruction needs.
  task automatic build_trace(input int kind, input int iw, input int dw, input logic z);
    rec_t r;
    trace.delete();
    for (int i = 0; i < iw; i++) begin
      r = mk(3'd0, z); r.imem_rdy = 1'b0; trace.push_back(r);
    end
    r = mk(3'd0, z); r.imem_rdy = 1'b1; r.o.ir_we = 1'b1; r.o.pc_we = 1'b1; trace.push_back(r);
    r = mk(3'd1, z); r.o.ill = (kind == K_ILL_OP || kind == K_ILL_FN); trace.push_back(r);
    if (kind == K_NOP || kind == K_ILL_OP || kind == K_ILL_FN) return;
    r = mk(3'd2, z);
    case (kind)
      K_SUBU: r.o.alu_op = 4'b0001;
      K_ORI:  begin r.o.alu_op = 4'b0010; r.o.src_b = 1'b1; end
      K_LUI:  begin r.o.alu_op = 4'b0100; r.o.src_b = 1'b1; end
      K_LW, K_SW: begin r.o.src_b = 1'b1; r.o.ext = 1'b1; end
      K_BEQ:  begin r.o.alu_op = 4'b0001; r.o.pc_src = 2'b01; r.o.pc_we = z; end
      K_J:    begin r.o.pc_we = 1'b1; r.o.pc_src = 2'b10; end
      K_JAL:  begin r.o.pc_we = 1'b1; r.o.pc_src = 2'b10; r.o.reg_we = 1'b1;
                    r.o.reg_dst = 2'b10; r.o.wb_sel = 2'b10; end
      K_JR:   begin r.o.pc_we = 1'b1; r.o.pc_src = 2'b11; end
      default: ;
    endcase
    trace.push_back(r);
    if (kind == K_LW || kind == K_SW) begin
      for (int i = 0; i <= dw; i++) begin
        r = mk(3'd3, z); r.dmem_rdy = (i == dw); r.o.src_b = 1'b1; r.o.ext = 1'b1;
        r.o.re = (kind == K_LW); r.o.we = (kind == K_SW);
        trace.push_back(r);
      end
    end
    if (kind inside {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW}) begin
      r = mk(3'd4, z); r.o.reg_we = 1'b1;
      r.o.reg_dst = (kind == K_ADDU || kind == K_SUBU) ? 2'b01 : 2'b00;
      r.o.wb_sel = (kind == K_LW) ? 2'b01 : 2'b00;
      trace.push_back(r);
    end
  endtask

  task automatic run_trace(input int n, input string name);
    outv_t       act;
    logic [31:0] cexp;
    for (int i = 0; i < n; i++) begin
      imem_ready = trace[i].imem_rdy;
      dmem_ready = trace[i].dmem_rdy;
      zero       = trace[i].zero;
      @(negedge clk);
      act = {state, ir_we, pc_we, pc_src, alu_op, alu_src_b, ext_op, reg_we,
             reg_dst, wb_sel, dmem_re, dmem_we, illegal};
      n_checks++;
      if (act !== trace[i].o)
        $display("FAIL %s cyc%0d outputs: got %h expected %h", name, i, act, trace[i].o);
      else n_pass++;
      if (i == 0) begin
        cexp = PERF ? cnt_model : 32'd0;
        n_checks++;
        if (instr_cnt !== cexp)
          $display("FAIL %s instr_cnt: got %0d expected %0d", name, instr_cnt, cexp);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input int kind, input int iw, input int dw, input logic z, input string name);
    opcode = op_of(kind);
    funct  = fn_of(kind);
    build_trace(kind, iw, dw, z);
    run_trace(trace.size(), name);
    if (kind != K_ILL_OP && kind != K_ILL_FN) cnt_model = cnt_model + 32'd1;
  endtask

  task automatic check_all_zero(input string name, input logic [2:0] exp_state);
    outv_t act, exp_v;
    exp_v = '0;
    exp_v.st = exp_state;
    act = {state, ir_we, pc_we, pc_src, alu_op, alu_src_b, ext_op, reg_we,
           reg_dst, wb_sel, dmem_re, dmem_we, illegal};
    n_checks++;
    if (act !== exp_v) $display("FAIL %s outputs: got %h expected %h", name, act, exp_v);
    else n_pass++;
    n_checks++;
    if (instr_cnt !== 32'd0) $display("FAIL %s instr_cnt: got %0d expected 0", name, instr_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1; zero = 1'b0;
    opcode = 6'h00; funct = 6'h00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all_zero("reset_hold", 3'd0);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    cnt_model = 0;
    run_instr(K_NOP, 0, 0, 1'b0, "reset_release");
  endtask

  task automatic test_addu_wait();
    run_instr(K_ADDU, 3, 0, 1'b0, "addu_wait");
  endtask

  task automatic test_beq();
    run_instr(K_BEQ, 0, 0, 1'b1, "beq_taken");
    run_instr(K_BEQ, 0, 0, 1'b0, "beq_not_taken");
  endtask

  task automatic test_mem();
    run_instr(K_LW, 0, 2, 1'b0, "lw_wait");
    run_instr(K_SW, 1, 1, 1'b0, "sw_wait");
    run_instr(K_LW, 0, 0, 1'b0, "lw_nowait");
  endtask

  task automatic test_illegal_and_jumps();
    run_instr(K_ILL_OP, 0, 0, 1'b0, "illegal_op");
    run_instr(K_ILL_FN, 1, 0, 1'b0, "illegal_fn");
    run_instr(K_JAL, 0, 0, 1'b0, "jal");
    run_instr(K_J, 0, 0, 1'b1, "j");
    run_instr(K_JR, 0, 0, 1'b0, "jr");
    run_instr(K_ORI, 0, 0, 1'b0, "ori");
    run_instr(K_LUI, 0, 0, 1'b0, "lui");
    run_instr(K_SUBU, 0, 0, 1'b1, "subu");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      run_instr($urandom_range(0, 12), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom), "random");
    end
  endtask

  task automatic test_reset_mid_exec();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    cnt_model = 0;
    for (int n = 0; n < 5; n++) run_instr(K_NOP, 0, 0, 1'b0, "pre_abort_nop");
    opcode = op_of(K_ADDU);
    funct  = fn_of(K_ADDU);
    build_trace(K_ADDU, 0, 0, 1'b0);
    run_trace(2, "abort_fetch_decode");
    n_checks++;
    if (instr_cnt !== (PERF ? 32'd5 : 32'd0))
      $display("FAIL abort_count_before: got %0d expected %0d", instr_cnt, PERF ? 5 : 0);
    else n_pass++;
    n_checks++;
    if (state !== 3'd2) $display("FAIL abort_in_exec state: got %0d expected 2", state);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_all_zero("abort_reset_low", 3'd0);
    @(posedge clk); #1;
    reset = 1'b1; imem_ready = 1'b0;
    @(negedge clk);
    check_all_zero("abort_after", 3'd0);
    @(posedge clk); #1;
    cnt_model = 0;
    run_instr(K_ADDU, 0, 0, 1'b0, "post_abort_addu");
  endtask

  task automatic test_wrap();
`ifdef MC_CTRL_PERF_EN
    dut.cnt_q = 32'hFFFF_FFFF;
    cnt_model = 32'hFFFF_FFFF;
    run_instr(K_NOP, 0, 0, 1'b0, "wrap_at_max");
    run_instr(K_NOP, 0, 0, 1'b0, "wrap_to_zero");
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_addu_wait();
    test_beq();
    test_mem();
    test_illegal_and_jumps();
    test_random();
    test_reset_mid_exec();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
